// File: rtl/stream_frame_writer_pkg.sv
// rtl/stream_frame_writer_pkg.sv - shared image-pipeline geometry defaults and writer FSM states
package stream_frame_writer_pkg;
    localparam int IM_WIDTH_DEF      = 320;
    localparam int IM_HEIGHT_DEF     = 240;
    localparam int IM_WIDTH_BITS_DEF = 9;
    localparam int ADDR_BITS_DEF     = 17;
    localparam int FIFO_DEPTH        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } writer_state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO; a push while full succeeds only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/stream_frame_writer.sv
// rtl/stream_frame_writer.sv - writes accepted pixels to memory in raster order via a 4-entry FIFO
module stream_frame_writer
    import stream_frame_writer_pkg::*;
#(
    parameter int work_mode     = 0,
    parameter int data_width    = 8,
    parameter int im_width      = IM_WIDTH_DEF,
    parameter int im_height     = IM_HEIGHT_DEF,
    parameter int im_width_bits = IM_WIDTH_BITS_DEF,
    parameter int addr_bits     = ADDR_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_ready,
    input  logic [data_width-1:0]    in_data,
    input  logic [im_width_bits-1:0] in_count_x,
    input  logic [im_width_bits-1:0] in_count_y,
    input  logic                     mem_busy,
    input  logic                     clr_err,
    output logic                     mem_we,
    output logic [addr_bits-1:0]     mem_addr,
    output logic [data_width-1:0]    mem_wdata,
    output logic                     frame_done,
    output logic                     err_range,
    output logic                     err_overflow
);
    localparam int FRAME_PIXELS = im_width * im_height;
    localparam int ENTRY_W      = addr_bits + data_width;

    logic                  r_in_ready_d;
    logic                  r_s1_valid;
    logic [addr_bits-1:0]  r_s1_addr;
    logic [data_width-1:0] r_s1_data;
    logic                  r_mem_we;
    logic [addr_bits-1:0]  r_mem_addr;
    logic [data_width-1:0] r_mem_wdata;
    logic                  r_frame_done;
    logic                  r_err_range;
    logic                  r_err_overflow;
    logic [addr_bits-1:0]  r_wr_count;
    writer_state_t         r_state;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_pop;
    logic                  w_overflow;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [addr_bits-1:0]  w_addr;
    logic [ENTRY_W-1:0]    w_fifo_rdata;

    // Mode 1 counts only the rising edge of in_ready as a new pixel.
    assign w_accept   = (work_mode == 0) ? in_ready : (in_ready & ~r_in_ready_d);
    assign w_in_range = (32'(in_count_x) < 32'(im_width)) && (32'(in_count_y) < 32'(im_height));
    assign w_addr     = addr_bits'(in_count_y) * addr_bits'(im_width) + addr_bits'(in_count_x);
    assign w_pop      = ~w_fifo_empty & ~mem_busy;
    assign w_overflow = r_s1_valid & w_fifo_full & ~w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s1_valid),
        .i_pop   (w_pop),
        .i_wdata ({r_s1_addr, r_s1_data}),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready_d   <= 1'b0;
            r_s1_valid     <= 1'b0;
            r_s1_addr      <= '0;
            r_s1_data      <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_err_range    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_in_ready_d <= in_ready;
            r_s1_valid   <= w_accept & w_in_range;
            if (w_accept) begin
                r_s1_addr <= w_addr;
                r_s1_data <= in_data;
            end
            r_mem_we <= w_pop;
            if (w_pop) {r_mem_addr, r_mem_wdata} <= w_fifo_rdata;
            // A new error event beats a simultaneous clear.
            r_err_range    <= (w_accept & ~w_in_range) | (r_err_range & ~clr_err);
            r_err_overflow <= w_overflow | (r_err_overflow & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wr_count   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_mem_we) begin
                if (r_wr_count == addr_bits'(FRAME_PIXELS - 1)) begin
                    r_wr_count   <= '0;
                    r_state      <= ST_DONE;
                    r_frame_done <= 1'b1;
                end else begin
                    r_wr_count <= r_wr_count + 1'b1;
                    r_state    <= ST_RUN;
                end
            end else if (r_state == ST_DONE) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign frame_done   = r_frame_done;
    assign err_range    = r_err_range;
    assign err_overflow = r_err_overflow;
endmodule

// File: tb/tb_stream_frame_writer.sv
// tb/tb_stream_frame_writer.sv - self-checking bench for stream_frame_writer
module tb_stream_frame_writer;
    localparam int W1 = 20;
    localparam int H1 = 12;
    localparam int N1 = W1 * H1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rdy0, busy0, clr0;
    logic [7:0]  data0;
    logic [8:0]  x0, y0;
    logic        we0, done0, er0, eo0;
    logic [16:0] addr0;
    logic [7:0]  wdata0;

    logic        rst1, rdy1, busy1, clr1;
    logic [7:0]  data1;
    logic [8:0]  x1, y1;
    logic        we1, done1, er1, eo1;
    logic [7:0]  addr1;
    logic [7:0]  wdata1;

    stream_frame_writer u0 (
        .clk(clk), .rst_n(rst0), .in_ready(rdy0), .in_data(data0),
        .in_count_x(x0), .in_count_y(y0), .mem_busy(busy0), .clr_err(clr0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .frame_done(done0), .err_range(er0), .err_overflow(eo0)
    );

    stream_frame_writer #(
        .work_mode(1), .data_width(8), .im_width(W1), .im_height(H1),
        .im_width_bits(9), .addr_bits(8)
    ) u1 (
        .clk(clk), .rst_n(rst1), .in_ready(rdy1), .in_data(data1),
        .in_count_x(x1), .in_count_y(y1), .mem_busy(busy1), .clr_err(clr1),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .frame_done(done1), .err_range(er1), .err_overflow(eo1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] pdata(input int a);
        return 8'(a * 13 + a / 320);
    endfunction

    // Reference model for u1: pixels take one cycle to reach a 4-deep queue, leave when memory is free.
    typedef struct packed { logic [7:0] a; logic [7:0] d; } ent_t;
    ent_t       m_q[$];
    ent_t       m_pipe;
    ent_t       m_e;
    bit         m_pv, m_prev, m_we, m_done, m_er, m_eo;
    logic [7:0] m_addr, m_data;
    int         m_cnt;

    always @(posedge clk) begin : model
        bit pop, full, acc;
        if (!rst1) begin
            m_q.delete();
            m_pv = 0; m_prev = 0; m_we = 0; m_done = 0; m_er = 0; m_eo = 0;
            m_addr = 0; m_data = 0; m_cnt = 0;
        end else begin
            full = (m_q.size() == 4);
            pop  = (m_q.size() != 0) && !busy1;
            m_done = 0;
            if (m_we) begin
                m_cnt++;
                if (m_cnt == N1) begin m_cnt = 0; m_done = 1; end
            end
            m_we = pop;
            if (pop) begin
                m_e = m_q.pop_front();
                m_addr = m_e.a;
                m_data = m_e.d;
            end
            m_eo = m_eo & ~clr1;
            if (m_pv) begin
                if (full && !pop) m_eo = 1;
                else m_q.push_back(m_pipe);
            end
            acc = rdy1 && !m_prev;
            m_prev = rdy1;
            m_er = m_er & ~clr1;
            m_pv = 0;
            if (acc) begin
                if (x1 < W1 && y1 < H1) begin
                    m_pv = 1;
                    m_pipe.a = 8'(y1 * W1 + x1);
                    m_pipe.d = data1;
                end else begin
                    m_er = 1;
                end
            end
        end
    end

    task automatic tick0();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
        chk("u1_we", we1, m_we);
        chk("u1_addr", addr1, m_addr);
        chk("u1_wdata", wdata1, m_data);
        chk("u1_done", done1, m_done);
        chk("u1_err_range", er1, m_er);
        chk("u1_err_ovf", eo1, m_eo);
    endtask

    initial begin
        int nw, nd, wbd, nexp;
        bit last_final;
        int ovf_order[5];
        ovf_order = '{0, 1, 2, 3, 7};

        rst0 = 0; rdy0 = 0; busy0 = 0; clr0 = 0; data0 = 0; x0 = 0; y0 = 0;
        rst1 = 0; rdy1 = 0; busy1 = 0; clr1 = 0; data1 = 0; x1 = 0; y1 = 0;
        tick0();
        tick1();
        chk("u0_reset_we", we0, 0);
        chk("u0_reset_addr", addr0, 0);
        chk("u0_reset_wdata", wdata0, 0);
        chk("u0_reset_done", done0, 0);
        chk("u0_reset_flags", {er0, eo0}, 0);

        // Mode 1: in_ready high through reset release, held 5 cycles
        rdy1 = 1; x1 = 3; y1 = 1; data1 = 8'h3C;
        tick1();
        rst1 = 1; nw = 0;
        repeat (5) begin tick1(); nw += int'(we1); end
        rdy1 = 0;
        repeat (4) begin tick1(); nw += int'(we1); end
        chk("m1_single_write", nw, 1);

        x1 = 320; y1 = 0; rdy1 = 1;
        tick1();
        rdy1 = 0;
        tick1();
        chk("m1_range_flag", er1, 1);
        clr1 = 1; rdy1 = 1;
        tick1();
        chk("m1_clr_vs_set", er1, 1);
        clr1 = 0; rdy1 = 0;
        tick1();
        clr1 = 1;
        tick1();
        chk("m1_range_cleared", er1, 0);
        clr1 = 0;

        // Forced overflow: pixels every other cycle while memory stalls
        busy1 = 1;
        for (int i = 0; i < 12; i++) begin
            rdy1 = (i % 2 == 0); x1 = 9'(i); y1 = 9'd3; data1 = 8'($urandom);
            tick1();
        end
        chk("m1_overflow_flag", eo1, 1);
        busy1 = 0; rdy1 = 0;
        repeat (10) tick1();

        repeat (800) begin
            rdy1  = 1'($urandom_range(0, 1));
            x1    = 9'($urandom_range(0, W1 + 1));
            y1    = 9'($urandom_range(0, H1));
            data1 = 8'($urandom);
            busy1 = ($urandom_range(0, 2) == 0);
            clr1  = ($urandom_range(0, 15) == 0);
            tick1();
        end
        rdy1 = 0; busy1 = 0; clr1 = 0;
        repeat (8) tick1();

        // Reset after 100 pixels, then a complete fresh frame
        for (int p = 0; p < 100; p++) begin
            rdy1 = 1; x1 = 9'(p % W1); y1 = 9'(p / W1); data1 = 8'($urandom);
            tick1();
            rdy1 = 0;
            tick1();
        end
        rst1 = 0;
        tick1();
        chk("m1_rst_outputs", {we1, addr1, wdata1, done1, er1, eo1}, 0);
        rst1 = 1;
        tick1();
        chk("m1_no_we_after_rst", we1, 0);
        nw = 0; nd = 0; wbd = -1;
        for (int p = 0; p < N1 + 4; p++) begin
            rdy1 = (p < N1); x1 = 9'(p % W1); y1 = 9'(p / W1); data1 = 8'($urandom);
            tick1();
            nw += int'(we1);
            if (done1) begin nd++; wbd = nw; end
            rdy1 = 0;
            tick1();
            nw += int'(we1);
            if (done1) begin nd++; wbd = nw; end
        end
        chk("m1_frame_writes", nw, N1);
        chk("m1_frame_done_count", nd, 1);
        chk("m1_done_after_writes", wbd, N1);

        // Mode 0: single pixel latency and address
        rst0 = 1;
        tick0();
        rdy0 = 1; x0 = 5; y0 = 2; data0 = 8'hA5;
        tick0();
        rdy0 = 0;
        chk("m0_lat_c1", we0, 0);
        tick0();
        chk("m0_lat_c2", we0, 0);
        tick0();
        chk("m0_single_we", we0, 1);
        chk("m0_single_addr", addr0, 645);
        chk("m0_single_data", wdata0, 8'hA5);
        tick0();
        chk("m0_hold_we", we0, 0);
        chk("m0_hold_addr", addr0, 645);
        chk("m0_hold_data", wdata0, 8'hA5);

        // Mode 0: memory busy for 8 cycles with a pixel every cycle
        for (int i = 0; i < 8; i++) begin
            busy0 = 1; rdy0 = 1; x0 = 9'(i); y0 = 0; data0 = 8'(8'h10 + i);
            tick0();
        end
        busy0 = 0; rdy0 = 0;
        chk("m0_overflow_flag", eo0, 1);
        for (int k = 0; k < 5; k++) begin
            tick0();
            chk("m0_drain_we", we0, 1);
            chk("m0_drain_addr", addr0, ovf_order[k]);
            chk("m0_drain_data", wdata0, 8'h10 + ovf_order[k]);
        end
        tick0();
        chk("m0_drain_end", we0, 0);
        chk("m0_no_range_err", er0, 0);
        clr0 = 1;
        tick0();
        clr0 = 0;
        chk("m0_ovf_cleared", eo0, 0);

        rst0 = 0;
        tick0();
        chk("m0_rst_outputs", {we0, addr0, wdata0, done0, er0, eo0}, 0);
        rst0 = 1;

        // Mode 0: full 320x240 raster with free memory
        nexp = 0; last_final = 0;
        for (int p = 0; p < 76800 + 6; p++) begin
            if (p < 76800) begin
                rdy0 = 1; x0 = 9'(p % 320); y0 = 9'(p / 320); data0 = pdata(p);
            end else begin
                rdy0 = 0;
            end
            tick0();
            chk("raster_done", done0, last_final);
            last_final = we0 && (nexp == 76799);
            if (we0) begin
                chk("raster_addr", addr0, nexp);
                chk("raster_data", wdata0, pdata(nexp));
                nexp++;
            end
        end
        chk("raster_count", nexp, 76800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
